// File: rtl/crc32_192_pkg.sv
// crc32_192_pkg: shared CRC32 constants, beat/state types and the 192-bit step function
package crc32_192_pkg;

    localparam logic [31:0] CRC_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;
    localparam int          BEAT_W     = 192;

    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WAIT_CRC,
        REPORT
    } state_t;

    // Non-reflected, MSB-first CRC update over one full beat; bit 191 enters first.
    function automatic logic [31:0] crc32_192_step(input logic [31:0] crc, input beat_t data);
        logic [31:0] c;
        c = crc;
        for (int i = BEAT_W - 1; i >= 0; i--) begin
            c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_192_step_comb.sv
// crc32_192_step_comb: combinational next-CRC over one 192-bit beat
//   crc_in  : running CRC before the beat
//   data    : beat payload, bit 191 processed first
//   crc_out : running CRC after the beat (no final inversion)
module crc32_192_step_comb
    import crc32_192_pkg::*;
(
    input  logic [31:0] crc_in,
    input  beat_t       data,
    output logic [31:0] crc_out
);

    always_comb crc_out = crc32_192_step(crc_in, data);

endmodule

// File: rtl/crc32_192bit_checker.sv
// crc32_192bit_checker: receive-side CRC32 checker for framed 192-bit beats
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous clear of state, counters and outputs (no report)
//   in_valid/sof/eof    : beat qualifiers; in_data is the 192-bit payload
//   exp_valid, exp_crc  : side-channel expected final CRC
//   res_valid           : one-cycle pulse per reported frame
//   res_match/timeout   : frame result, valid with res_valid
//   res_crc             : computed final CRC of the last reported frame
//   proto_err           : one-cycle pulse on a framing violation
//   frame_count         : saturating count of reported frames
//   err_count           : saturating count of mismatches, timeouts and aborts
module crc32_192bit_checker
    import crc32_192_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eof,
    input  logic [191:0]     in_data,
    input  logic             exp_valid,
    input  logic [31:0]      exp_crc,
    output logic             res_valid,
    output logic             res_match,
    output logic             res_timeout,
    output logic [31:0]      res_crc,
    output logic             proto_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [31:0]   crc, exp_reg, step_in, step_out, exp_cur;
    logic [TW-1:0] timer;
    logic          exp_pending, exp_avail, timer_done, match_now;
    logic          start, accum, report, rpt_timeout, abort, perr;
    logic          load, eof_beat, cap, drop, err_inc;

    // A SOF beat always restarts from INIT, so one step unit serves every state.
    assign step_in = in_sof ? CRC_INIT : crc;

    crc32_192_step_comb u_step (
        .crc_in (step_in),
        .data   (in_data),
        .crc_out(step_out)
    );

    // A same-cycle strobe is newer than anything latched earlier.
    assign exp_avail  = exp_valid | exp_pending;
    assign exp_cur    = exp_valid ? exp_crc : exp_reg;
    assign timer_done = timer == TW'(TIMEOUT - 1);
    assign match_now  = ~rpt_timeout & ((crc ^ CRC_XOROUT) == exp_cur);

    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        accum       = 1'b0;
        report      = 1'b0;
        rpt_timeout = 1'b0;
        abort       = 1'b0;
        perr        = 1'b0;
        case (state)
            IDLE, REPORT: begin
                start    = in_valid & in_sof;
                perr     = in_valid & ~in_sof;
                state_nx = IDLE;
            end
            ACCUM: begin
                accum = in_valid;
                abort = in_valid & in_sof;
                perr  = abort;
                if (in_valid && in_eof) state_nx = WAIT_CRC;
            end
            WAIT_CRC: begin
                start       = in_valid & in_sof;
                perr        = in_valid & ~in_sof;
                report      = exp_avail | timer_done | start;
                rpt_timeout = ~exp_avail;
                if (report) state_nx = REPORT;
            end
            default: state_nx = IDLE;
        endcase
        // A new frame overrides the plain next state; its report (if any) still fires.
        if (start) state_nx = in_eof ? WAIT_CRC : ACCUM;
    end

    assign load     = start | accum;
    assign eof_beat = load & in_eof;
    assign cap      = exp_valid & ((state == ACCUM) | eof_beat);
    assign drop     = report | abort | (state == REPORT);
    assign err_inc  = abort | (report & ~match_now);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= clear ? IDLE : state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc         <= CRC_INIT;
            exp_reg     <= '0;
            exp_pending <= 1'b0;
            timer       <= '0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_timeout <= 1'b0;
            res_crc     <= '0;
            proto_err   <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else if (clear) begin
            crc         <= CRC_INIT;
            exp_reg     <= '0;
            exp_pending <= 1'b0;
            timer       <= '0;
            res_valid   <= 1'b0;
            res_match   <= 1'b0;
            res_timeout <= 1'b0;
            res_crc     <= '0;
            proto_err   <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (load) crc <= step_out;
            if (cap) exp_reg <= exp_crc;
            exp_pending <= cap ? 1'b1 : drop ? 1'b0 : exp_pending;
            // Restarts at zero whenever WAIT_CRC is (re)entered or left.
            timer       <= (state == WAIT_CRC && !report) ? timer + TW'(1) : '0;
            res_valid   <= report;
            proto_err   <= perr;
            if (report) begin
                res_match   <= match_now;
                res_timeout <= rpt_timeout;
                res_crc     <= crc ^ CRC_XOROUT;
            end
            if (report && !(&frame_count)) frame_count <= frame_count + CNT_W'(1);
            if (err_inc && !(&err_count)) err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_crc32_192bit_checker.sv
// tb_crc32_192bit_checker: self-checking bench with a frame-level CRC reference model
module tb_crc32_192bit_checker;

    localparam int CW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n, clear, in_valid, in_sof, in_eof, exp_valid;
    logic [191:0]  in_data;
    logic [31:0]   exp_crc;
    logic          res_valid, res_match, res_timeout, proto_err;
    logic [31:0]   res_crc;
    logic [CW-1:0] frame_count, err_count;

    crc32_192bit_checker #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .in_data    (in_data),
        .exp_valid  (exp_valid),
        .exp_crc    (exp_crc),
        .res_valid  (res_valid),
        .res_match  (res_match),
        .res_timeout(res_timeout),
        .res_crc    (res_crc),
        .proto_err  (proto_err),
        .frame_count(frame_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        bit          t;
        logic [31:0] crc;
        int          c;
    } rep_t;

    typedef struct {
        bit clr;
        int n;
        int kind;
        int mode;
        int dly;
        bit corr;
        bit em;
        bit et;
        int lat;
        int fc;
        int ec;
    } vec_t;

    int           total = 0;
    int           bad = 0;
    int           cnt = 0;
    int           pcnt = 0;
    rep_t         rq[$];
    logic [191:0] beat_q[$];
    vec_t         tbl[8];

    always @(posedge clk) cnt <= cnt + 1;

    always @(negedge clk) begin
        if (res_valid) rq.push_back('{res_match, res_timeout, res_crc, cnt});
        if (proto_err) pcnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic beat(input bit s, input bit e, input logic [191:0] d, input bit ev, input logic [31:0] ec);
        in_valid  = 1'b1;
        in_sof    = s;
        in_eof    = e;
        in_data   = d;
        exp_valid = ev;
        exp_crc   = ec;
        cyc();
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_eof    = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic build(input int n, input int kind);
        beat_q.delete();
        for (int i = 0; i < n; i++) begin
            if (kind == 0) beat_q.push_back('0);
            else if (kind == 1) beat_q.push_back({6{32'(i)}});
            else beat_q.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        end
    endtask

    // Whole-frame polynomial division over the concatenated bit stream.
    function automatic logic [31:0] ref_crc();
        bit          bits[$];
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (beat_q[k]) for (int i = 191; i >= 0; i--) bits.push_back(beat_q[k][i]);
        foreach (bits[j]) begin
            fb = r[31] ^ bits[j];
            r  = r << 1;
            if (fb) r = r ^ 32'h04C1_1DB7;
        end
        return ~r;
    endfunction

    // mode 0: exp with EOF beat, 1: exp on middle beat, 2: exp dly cycles after EOF, 3: never
    task automatic drive_frame(input int mode, input int dly, input logic [31:0] expv, output int eofc);
        int n;
        bit ev;
        n = beat_q.size();
        eofc = 0;
        for (int i = 0; i < n; i++) begin
            ev = (mode == 0 && i == n - 1) || (mode == 1 && i == n / 2);
            if (i == n - 1) eofc = cnt;
            beat(i == 0, i == n - 1, beat_q[i], ev, expv);
        end
        if (mode == 2) begin
            repeat (dly - 1) cyc();
            exp_valid = 1'b1;
            exp_crc   = expv;
            cyc();
            exp_valid = 1'b0;
        end
    endtask

    task automatic check_report(input string nm, input bit em, input bit et, input logic [31:0] ecrc,
                                input int elat, input int eofc);
        rep_t r;
        int   w;
        w = 0;
        while (rq.size() == 0 && w < 30) begin
            cyc();
            w++;
        end
        if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s report: got none within 30 cycles want res_valid", nm);
        end else begin
            r = rq.pop_front();
            chk({nm, " match"}, 64'(r.m), 64'(em));
            chk({nm, " timeout"}, 64'(r.t), 64'(et));
            chk({nm, " crc"}, 64'(r.crc), 64'(ecrc));
            chk({nm, " latency"}, 64'(r.c - eofc), 64'(elat));
        end
    endtask

    task automatic frame_test(input string nm, input int n, input int kind, input int mode, input int dly,
                              input bit corr, input bit em, input bit et, input int lat,
                              input int fc, input int ec);
        logic [31:0] g;
        int          eofc;
        build(n, kind);
        g = ref_crc();
        drive_frame(mode, dly, corr ? g ^ 32'h1 : g, eofc);
        check_report(nm, em, et, g, lat, eofc);
        chk({nm, " frame_count"}, 64'(frame_count), 64'(fc));
        chk({nm, " err_count"}, 64'(err_count), 64'(ec));
    endtask

    function automatic int sat(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    initial begin
        logic [31:0] g1, g2;
        int          e1, e2, p0, mf, me, n, kind, mode, dly;
        bit          corr, isbad;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        in_data = '0; exp_valid = 1'b0; exp_crc = '0;

        tbl[0] = '{0, 1, 0, 2, 1, 0, 1, 0, 2, 1, 0};
        tbl[1] = '{0, 4, 1, 1, 0, 1, 0, 0, 2, 2, 1};
        tbl[2] = '{0, 1, 2, 3, 0, 0, 0, 1, 9, 3, 2};
        tbl[3] = '{1, 3, 2, 0, 0, 0, 1, 0, 2, 1, 0};
        tbl[4] = '{0, 2, 1, 2, 7, 0, 1, 0, 8, 2, 0};
        tbl[5] = '{0, 2, 2, 2, 4, 1, 0, 0, 5, 3, 1};
        tbl[6] = '{0, 3, 0, 0, 0, 0, 1, 0, 2, 3, 1};
        tbl[7] = '{0, 1, 1, 2, 7, 1, 0, 0, 8, 3, 2};

        repeat (3) cyc();
        chk("reset outputs", 64'({res_valid, res_match, res_timeout, res_crc, proto_err, frame_count, err_count}), 64'(0));
        rst_n = 1'b1;
        cyc();

        foreach (tbl[i]) begin
            if (tbl[i].clr) do_clear();
            frame_test($sformatf("vec%0d", i), tbl[i].n, tbl[i].kind, tbl[i].mode, tbl[i].dly, tbl[i].corr,
                       tbl[i].em, tbl[i].et, tbl[i].lat, tbl[i].fc, tbl[i].ec);
        end

        // Abort: SOF on the third beat of a frame still in ACCUM.
        do_clear();
        p0 = pcnt;
        beat(1'b1, 1'b0, {6{32'h1111_1111}}, 1'b0, '0);
        beat(1'b0, 1'b0, {6{32'h2222_2222}}, 1'b0, '0);
        build(3, 2);
        g1 = ref_crc();
        beat(1'b1, 1'b0, beat_q[0], 1'b0, '0);
        chk("abort proto_err", 64'(proto_err), 64'(1));
        chk("abort err_count", 64'(err_count), 64'(1));
        beat(1'b0, 1'b0, beat_q[1], 1'b0, '0);
        e1 = cnt;
        beat(1'b0, 1'b1, beat_q[2], 1'b1, g1);
        chk("abort no report", 64'(rq.size()), 64'(0));
        check_report("restart", 1'b1, 1'b0, g1, 2, e1);
        chk("restart frame_count", 64'(frame_count), 64'(1));
        chk("restart err_count", 64'(err_count), 64'(1));
        chk("abort proto pulses", 64'(pcnt - p0), 64'(1));

        // Back-to-back: second SOF lands in the REPORT cycle of the first frame.
        do_clear();
        build(2, 2);
        g1 = ref_crc();
        drive_frame(0, 0, g1, e1);
        cyc();
        build(2, 2);
        g2 = ref_crc();
        drive_frame(0, 0, g2, e2);
        check_report("b2b first", 1'b1, 1'b0, g1, 2, e1);
        check_report("b2b second", 1'b1, 1'b0, g2, 2, e2);
        chk("b2b frame_count", 64'(frame_count), 64'(2));
        chk("b2b err_count", 64'(err_count), 64'(0));

        // Saturation over five bad frames, then clear.
        do_clear();
        for (int i = 0; i < 5; i++) begin
            frame_test($sformatf("sat%0d", i), 1, 2, 0, 0, 1'b1, 1'b0, 1'b0, 2, sat(i + 1), sat(i + 1));
        end
        do_clear();
        chk("clear frame_count", 64'(frame_count), 64'(0));
        chk("clear err_count", 64'(err_count), 64'(0));
        beat(1'b0, 1'b0, '0, 1'b0, '0);
        chk("idle stray proto_err", 64'(proto_err), 64'(1));

        // Clear mid-frame drops the frame and returns to IDLE.
        frame_test("pre", 1, 2, 0, 0, 1'b0, 1'b1, 1'b0, 2, 1, 0);
        beat(1'b1, 1'b0, '1, 1'b0, '0);
        do_clear();
        beat(1'b0, 1'b1, '1, 1'b1, 32'h1234_5678);
        chk("clear midframe idle", 64'(proto_err), 64'(1));
        repeat (4) cyc();
        chk("clear midframe no report", 64'(rq.size()), 64'(0));

        // Async reset mid-frame with nonzero outputs beforehand.
        frame_test("pre2", 1, 2, 0, 0, 1'b1, 1'b0, 1'b0, 2, 1, 1);
        beat(1'b1, 1'b0, '1, 1'b0, '0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 64'({res_valid, res_match, res_timeout, res_crc, proto_err, frame_count, err_count}), 64'(0));
        cyc();
        rst_n = 1'b1;
        cyc();

        // Randomized frames against the frame-level model.
        mf = 0;
        me = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 6 == 5) begin
                do_clear();
                mf = 0;
                me = 0;
            end
            repeat ($urandom_range(0, 2)) cyc();
            n     = $urandom_range(1, 4);
            kind  = $urandom_range(0, 2);
            mode  = $urandom_range(0, 3);
            dly   = $urandom_range(1, 7);
            corr  = 1'($urandom_range(0, 1));
            isbad = corr || mode == 3;
            mf    = sat(mf + 1);
            me    = isbad ? sat(me + 1) : me;
            frame_test($sformatf("rnd%0d", k), n, kind, mode, dly, corr, !isbad, mode == 3,
                       mode <= 1 ? 2 : mode == 2 ? dly + 1 : TO + 1, mf, me);
        end

        repeat (12) cyc();
        chk("no stray reports", 64'(rq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
